// File: rtl/branch_predict_unit.sv
// branch_predict_unit: RV32 branch resolver with a PC-indexed 2-bit counter predictor.
// Defining PERF_COUNTERS_EN builds saturating branch and mispredict counters.
module branch_predict_unit #(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            Valid,
  input  logic [XLEN-1:0] PC,
  input  logic [XLEN-1:0] RUrs1,
  input  logic [XLEN-1:0] RUrs2,
  input  logic [4:0]      BrOp,
  output logic            NextPCSrc,
  output logic            PredTaken,
  output logic            Mispredict,
  output logic [31:0]     BrCount,
  output logic [31:0]     MissCount
);
  localparam int IDX_W = $clog2(BHT_DEPTH);
  logic [BHT_DEPTH-1:0][1:0] ctr_q;
  logic [IDX_W-1:0] idx;
  logic [1:0] cur, ctr_d;
  logic is_uncond, is_cond, eq, lt, ltu, cmp, upd;
  logic unused_pc;
  assign unused_pc = ^{PC[XLEN-1:IDX_W+2], PC[1:0]};
  assign idx = PC[IDX_W+1:2];
  assign cur = ctr_q[idx];
  assign is_uncond = BrOp[4];
  // 0101x is reserved and behaves as no branch
  assign is_cond = (BrOp[4:3] == 2'b01) && (BrOp[2:1] != 2'b01);
  assign eq = RUrs1 == RUrs2;
  assign lt = $signed(RUrs1) < $signed(RUrs2);
  assign ltu = RUrs1 < RUrs2;
  // BrOp[0] inverts the base comparison: BNE/BGE/BGEU
  assign cmp = (BrOp[2] ? (BrOp[1] ? ltu : lt) : eq) ^ BrOp[0];
  assign NextPCSrc = is_uncond | (is_cond & cmp);
  assign PredTaken = is_uncond ? 1'b1 : is_cond ? cur[1] : 1'b0;
  assign Mispredict = Valid & ~rst & (PredTaken != NextPCSrc);
  assign upd = Valid & is_cond;
  always_comb begin
    ctr_d = NextPCSrc ? ((cur == 2'b11) ? cur : cur + 2'b01)
                      : ((cur == 2'b00) ? cur : cur - 2'b01);
  end
  always_ff @(posedge clk) begin
    if (rst) ctr_q <= {BHT_DEPTH{2'b01}};
    else if (upd) ctr_q[idx] <= ctr_d;
  end
`ifdef PERF_COUNTERS_EN
  logic [31:0] br_q, br_d, miss_q, miss_d;
  always_comb begin
    br_d = (upd && br_q != '1) ? br_q + 32'd1 : br_q;
    miss_d = (Mispredict && miss_q != '1) ? miss_q + 32'd1 : miss_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      br_q <= '0;
      miss_q <= '0;
    end else begin
      br_q <= br_d;
      miss_q <= miss_d;
    end
  end
  assign BrCount = br_q;
  assign MissCount = miss_q;
`else
  assign BrCount = 32'd0;
  assign MissCount = 32'd0;
`endif
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed and random checks against a table-of-counters reference model.
module tb_branch_predict_unit;
  logic clk = 1'b0, rst = 1'b1, Valid = 1'b0;
  logic [31:0] PC = '0, RUrs1 = '0, RUrs2 = '0;
  logic [4:0] BrOp = '0;
  logic NextPCSrc, PredTaken, Mispredict;
  logic [31:0] BrCount, MissCount;
  int errors = 0, checks = 0;
  int ctr [16];
  longint brc, missc;
`ifdef PERF_COUNTERS_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  branch_predict_unit dut (
    .clk(clk), .rst(rst), .Valid(Valid), .PC(PC), .RUrs1(RUrs1), .RUrs2(RUrs2),
    .BrOp(BrOp), .NextPCSrc(NextPCSrc), .PredTaken(PredTaken),
    .Mispredict(Mispredict), .BrCount(BrCount), .MissCount(MissCount)
  );

  always #5 clk = ~clk;

  function automatic bit is_cond(input logic [4:0] op);
    return op inside {5'b01000, 5'b01001, 5'b01100, 5'b01101, 5'b01110, 5'b01111};
  endfunction

  function automatic bit ref_taken(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[4]) return 1'b1;
    case (op)
      5'b01000: return a == b;
      5'b01001: return a != b;
      5'b01100: return $signed(a) < $signed(b);
      5'b01101: return $signed(a) >= $signed(b);
      5'b01110: return a < b;
      5'b01111: return a >= b;
      default:  return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    foreach (ctr[i]) ctr[i] = 1;
    brc = 0;
    missc = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, check the combinational outputs and counters, then advance the model.
  task automatic step(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] op, input bit v, input bit r);
    int i;
    bit t, p;
    @(negedge clk);
    PC = pc; RUrs1 = a; RUrs2 = b; BrOp = op; Valid = v; rst = r;
    #1;
    i = (pc >> 2) % 16;
    t = ref_taken(op, a, b);
    p = op[4] ? 1'b1 : is_cond(op) ? (ctr[i] >= 2) : 1'b0;
    chk("NextPCSrc", 32'(NextPCSrc), 32'(t));
    chk("PredTaken", 32'(PredTaken), 32'(p));
    chk("Mispredict", 32'(Mispredict), 32'(v && !r && p != t));
    chk("BrCount", BrCount, PERF ? 32'(brc) : 32'd0);
    chk("MissCount", MissCount, PERF ? 32'(missc) : 32'd0);
    if (r) model_reset();
    else if (v) begin
      if (p != t && missc < 64'hFFFF_FFFF) missc++;
      if (is_cond(op)) begin
        ctr[i] = t ? ((ctr[i] < 3) ? ctr[i] + 1 : 3) : ((ctr[i] > 0) ? ctr[i] - 1 : 0);
        if (brc < 64'hFFFF_FFFF) brc++;
      end
    end
  endtask

  initial begin
    logic [4:0] ops [12];
    logic [31:0] a, b;
    ops = '{5'h00, 5'h07, 5'h10, 5'h1f, 5'h08, 5'h09, 5'h0c, 5'h0d, 5'h0e, 5'h0f, 5'h0a, 5'h0b};
    repeat (2) @(posedge clk);
    model_reset();
    step(32'h0, 0, 0, 5'b00000, 0, 0);
    chk("reset_brcount", BrCount, 32'd0);
    // first BEQ after reset mispredicts, second predicts taken
    step(32'h10, 30, 30, 5'b01000, 1, 0);
    chk("t1_next", 32'(NextPCSrc), 1);
    chk("t1_pred0", 32'(PredTaken), 0);
    chk("t1_mis0", 32'(Mispredict), 1);
    step(32'h10, 30, 30, 5'b01000, 1, 0);
    chk("t1_pred1", 32'(PredTaken), 1);
    chk("t1_mis1", 32'(Mispredict), 0);
    repeat (4) step(32'h20, -10, -20, 5'b01100, 1, 0);
    step(32'h20, -20, -10, 5'b01100, 1, 0);
    step(32'h20, -20, -10, 5'b01100, 1, 0);
    chk("t2_sat_pred", 32'(PredTaken), 0);
    step(32'h24, 10, 32'hFFFF_FFEC, 5'b01110, 1, 0);
    chk("t3_bltu", 32'(NextPCSrc), 1);
    step(32'h28, 32'hFFFF_FFEC, 10, 5'b01111, 1, 0);
    chk("t3_bgeu", 32'(NextPCSrc), 1);
    step(32'h2c, -20, -10, 5'b01101, 1, 0);
    chk("t3_bge", 32'(NextPCSrc), 0);
    step(32'h2c, 30, 20, 5'b01001, 1, 0);
    chk("t3_bne", 32'(NextPCSrc), 1);
    repeat (2) step(32'h10, 5, 5, 5'b01000, 1, 0);
    step(32'h50, 1, 2, 5'b01000, 1, 0);
    chk("t4_alias_pred", 32'(PredTaken), 1);
    step(32'h60, 1, 2, 5'b10000, 1, 0);
    chk("t5_uncond", 32'({NextPCSrc, PredTaken}), 3);
    step(32'h60, 1, 1, 5'b00000, 1, 0);
    chk("t5_nobranch", 32'({NextPCSrc, PredTaken}), 0);
    step(32'h60, 1, 1, 5'b01010, 1, 0);
    chk("t5_reserved", 32'({NextPCSrc, PredTaken}), 0);
    repeat (3) step(32'h30, 7, 7, 5'b01000, 1, 0);
    step(32'h30, 7, 8, 5'b01001, 1, 1);
    chk("t6_mis_rst", 32'(Mispredict), 0);
    step(32'h30, 7, 7, 5'b01000, 1, 0);
    chk("t6_pred_after_rst", 32'(PredTaken), 0);
    for (int n = 0; n < 400; n++) begin
      a = ($urandom_range(0, 1) != 0) ? $urandom : 32'($signed($urandom_range(0, 40)) - 20);
      b = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) != 0) ? $urandom : 32'($signed($urandom_range(0, 40)) - 20));
      step({$urandom_range(0, 63), 2'($urandom)}, a, b, ops[$urandom_range(0, 11)],
           $urandom_range(0, 7) != 0, $urandom_range(0, 49) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
